// File: rtl/data_mem_resp.sv
// Data-memory slave for the RV32 core: word RAM plus MMIO console FIFO, cycle counter (DMEM_CYCLE_CNT_EN), halt flag.
// Latency: reads combinational (0 cycles), writes commit at the rising edge.
// Backpressure: none toward the core; console drains via valid/ready, full pushes are dropped and flagged in ovf.
module data_mem_resp #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_ce_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        con_valid_o,
    output logic [7:0]  con_data_o,
    input  logic        con_ready_i,
    output logic        halt_o,
    output logic        bad_addr_o
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [7:0]  fifo_q [4];

    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       ovf_q, ovf_d;
    logic       halt_q, halt_d;
    logic       bad_q, bad_d;
`ifdef DMEM_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;
`endif

    logic          acc, wr;
    logic          sel_ram, sel_mmio, sel_con, sel_cyc, sel_halt, sel_clr;
    logic [AW-1:0] ram_idx;
    logic          fifo_empty, fifo_full, pop, push;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^data_addr_i[1:0];

    // Reset masks the access entirely: no state change and zero read data.
    assign acc      = data_ce_i && !rst;
    assign wr       = acc && data_we_i;
    assign sel_ram  = data_addr_i < RAM_BYTES;
    assign sel_mmio = !sel_ram && (data_addr_i[31:4] == MMIO_BASE[31:4]);
    assign sel_con  = sel_mmio && (data_addr_i[3:2] == 2'd0);
    assign sel_cyc  = sel_mmio && (data_addr_i[3:2] == 2'd1);
    assign sel_halt = sel_mmio && (data_addr_i[3:2] == 2'd2);
    assign sel_clr  = sel_mmio && (data_addr_i[3:2] == 2'd3);
    assign ram_idx  = data_addr_i[AW+1:2];

    assign fifo_empty = (count_q == 3'd0);
    assign fifo_full  = (count_q == 3'd4);
    assign pop        = !fifo_empty && con_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign push       = wr && sel_con && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        halt_d   = halt_q;
        bad_d    = bad_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        if (push && !pop) begin
            count_d = count_q + 3'd1;
        end else if (pop && !push) begin
            count_d = count_q - 3'd1;
        end

        if (wr && sel_con && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
        if (wr && sel_clr) begin
            ovf_d = 1'b0;
        end
        if (wr && sel_halt && data_wdata_i[0]) begin
            halt_d = 1'b1;
        end
        if (acc && !sel_ram && !sel_mmio) begin
            bad_d = 1'b1;
        end
    end

`ifdef DMEM_CYCLE_CNT_EN
    // A CPU write replaces this cycle's increment.
    always_comb begin
        cyc_d = cyc_q + 32'd1;
        if (wr && sel_cyc) begin
            cyc_d = data_wdata_i;
        end
    end
`endif

    always_comb begin
        data_rdata_o = 32'h0;
        if (acc) begin
            if (sel_ram) begin
                data_rdata_o = mem_q[ram_idx];
            end else if (sel_con) begin
                data_rdata_o = {25'b0, count_q, 1'b0, ovf_q, fifo_full, fifo_empty};
            end else if (sel_cyc) begin
`ifdef DMEM_CYCLE_CNT_EN
                data_rdata_o = cyc_q;
`else
                data_rdata_o = 32'h0;
`endif
            end else if (sel_halt) begin
                data_rdata_o = {31'b0, halt_q};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            ovf_q    <= 1'b0;
            halt_q   <= 1'b0;
            bad_q    <= 1'b0;
`ifdef DMEM_CYCLE_CNT_EN
            cyc_q    <= 32'd0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            halt_q   <= halt_d;
            bad_q    <= bad_d;
`ifdef DMEM_CYCLE_CNT_EN
            cyc_q    <= cyc_d;
`endif
        end
    end

    // Storage arrays are not reset; the pointers alone define FIFO contents.
    always_ff @(posedge clk) begin
        if (wr && sel_ram) begin
            mem_q[ram_idx] <= data_wdata_i;
        end
        if (push) begin
            fifo_q[wr_ptr_q] <= data_wdata_i[7:0];
        end
    end

    assign con_valid_o = !fifo_empty;
    assign con_data_o  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
    assign halt_o      = halt_q;
    assign bad_addr_o  = bad_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: directed scenarios then randomized traffic against a queue-based model.
module tb_data_mem_resp;
    localparam int          DEPTH  = 1024;
    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] A_CON  = BASE;
    localparam logic [31:0] A_CYC  = BASE + 32'h4;
    localparam logic [31:0] A_HALT = BASE + 32'h8;
    localparam logic [31:0] A_CLR  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce, we;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;
    logic        halt, bad;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_resp #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_ce_i    (ce),
        .data_we_i    (we),
        .data_addr_i  (addr),
        .data_wdata_i (wdata),
        .data_rdata_o (rdata),
        .con_valid_o  (con_valid),
        .con_data_o   (con_data),
        .con_ready_i  (con_ready),
        .halt_o       (halt),
        .bad_addr_o   (bad)
    );

    task automatic drive(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
        ce = c; we = w; addr = a; wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; con_ready = 1'b0;
        drive(1'b1, 1'b0, A_HALT, 32'h0);
        tick(); tick(); #1;
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        n_checks++; if (con_valid !== 1'b0) begin n_fail++; $display("FAIL reset_con_valid: got %b want 0", con_valid); end
        n_checks++; if (con_data !== 8'h0) begin n_fail++; $display("FAIL reset_con_data: got %h want 0", con_data); end
        n_checks++; if (halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %b want 0", halt); end
        n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL reset_bad: got %b want 0", bad); end
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, A_CON, 32'h0); #1;
        n_checks++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL reset_status: got %h want 00000001", rdata); end
        tick();
    endtask

    task automatic test_ram();
        drive(1'b1, 1'b1, 32'h40, 32'hDEADBEEF); tick();
        drive(1'b1, 1'b0, 32'h40, 32'h0); #1;
        n_checks++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_rd: got %h want deadbeef", rdata); end
        tick();
    endtask

    task automatic test_same_cycle();
        drive(1'b1, 1'b1, 32'h44, 32'h22); tick();
        drive(1'b1, 1'b1, 32'h44, 32'h11); #1;
        n_checks++; if (rdata !== 32'h22) begin n_fail++; $display("FAIL rw_old: got %h want 00000022", rdata); end
        tick();
        drive(1'b1, 1'b0, 32'h44, 32'h0); #1;
        n_checks++; if (rdata !== 32'h11) begin n_fail++; $display("FAIL rw_new: got %h want 00000011", rdata); end
        tick();
    endtask

    task automatic test_console_ovf();
        logic [7:0] exp;
        con_ready = 1'b0;
        drive(1'b1, 1'b1, A_CLR, 32'h0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, A_CON, 32'h41 + 32'(i)); tick();
        end
        drive(1'b1, 1'b0, A_CON, 32'h0); #1;
        n_checks++; if (rdata !== 32'h46) begin n_fail++; $display("FAIL ovf_status: got %h want 00000046", rdata); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0); con_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = 8'h41 + 8'(i);
            #1;
            n_checks++; if (con_valid !== 1'b1 || con_data !== exp) begin
                n_fail++; $display("FAIL ovf_drain%0d: got v=%b d=%h want v=1 d=%h", i, con_valid, con_data, exp);
            end
            tick();
        end
        #1;
        n_checks++; if (con_valid !== 1'b0 || con_data !== 8'h0) begin
            n_fail++; $display("FAIL ovf_empty: got v=%b d=%h want v=0 d=00", con_valid, con_data);
        end
        con_ready = 1'b0;
        drive(1'b1, 1'b0, A_CON, 32'h0); #1;
        n_checks++; if (rdata !== 32'h05) begin n_fail++; $display("FAIL ovf_sticky: got %h want 00000005", rdata); end
        tick();
    endtask

    task automatic test_full_push_pop();
        logic [7:0] seq [4];
        seq[0] = 8'h02; seq[1] = 8'h03; seq[2] = 8'h04; seq[3] = 8'h5A;
        con_ready = 1'b0;
        drive(1'b1, 1'b1, A_CLR, 32'h0); tick();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, A_CON, 32'(i)); tick();
        end
        con_ready = 1'b1;
        drive(1'b1, 1'b1, A_CON, 32'h5A); #1;
        n_checks++; if (con_data !== 8'h01) begin n_fail++; $display("FAIL fpp_head: got %h want 01", con_data); end
        tick();
        con_ready = 1'b0;
        drive(1'b1, 1'b0, A_CON, 32'h0); #1;
        n_checks++; if (rdata !== 32'h42) begin n_fail++; $display("FAIL fpp_status: got %h want 00000042", rdata); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0); con_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (con_valid !== 1'b1 || con_data !== seq[i]) begin
                n_fail++; $display("FAIL fpp_drain%0d: got v=%b d=%h want v=1 d=%h", i, con_valid, con_data, seq[i]);
            end
            tick();
        end
        #1;
        n_checks++; if (con_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_empty: got %b want 0", con_valid); end
        con_ready = 1'b0;
        tick();
    endtask

    task automatic test_cycle();
        logic [31:0] exp [3];
`ifdef DMEM_CYCLE_CNT_EN
        exp[0] = 32'hFFFF_FFFE; exp[1] = 32'hFFFF_FFFF; exp[2] = 32'h0;
`else
        exp[0] = 32'h0; exp[1] = 32'h0; exp[2] = 32'h0;
`endif
        drive(1'b1, 1'b1, A_CYC, 32'hFFFF_FFFE); tick();
        drive(1'b1, 1'b0, A_CYC, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (rdata !== exp[i]) begin n_fail++; $display("FAIL cycle_rd%0d: got %h want %h", i, rdata, exp[i]); end
            tick();
        end
        n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL cycle_bad: got %b want 0", bad); end
    endtask

    task automatic test_halt_bad();
        drive(1'b1, 1'b1, A_HALT, 32'h1); #1;
        n_checks++; if (halt !== 1'b0) begin n_fail++; $display("FAIL halt_early: got %b want 0", halt); end
        tick();
        drive(1'b1, 1'b1, A_HALT, 32'h0); #1;
        n_checks++; if (halt !== 1'b1) begin n_fail++; $display("FAIL halt_set: got %b want 1", halt); end
        tick();
        drive(1'b1, 1'b0, A_HALT, 32'h0); #1;
        n_checks++; if (halt !== 1'b1 || rdata !== 32'h1) begin
            n_fail++; $display("FAIL halt_hold: got halt=%b rd=%h want halt=1 rd=00000001", halt, rdata);
        end
        tick();
        drive(1'b1, 1'b0, BASE + 32'h20, 32'h0); #1;
        n_checks++; if (rdata !== 32'h0 || bad !== 1'b0) begin
            n_fail++; $display("FAIL bad_rd: got rd=%h bad=%b want rd=0 bad=0", rdata, bad);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0); #1;
        n_checks++; if (bad !== 1'b1) begin n_fail++; $display("FAIL bad_set: got %b want 1", bad); end
        rst = 1'b1; tick(); #1;
        n_checks++; if (halt !== 1'b0 || bad !== 1'b0) begin
            n_fail++; $display("FAIL flags_reset: got halt=%b bad=%b want 0 0", halt, bad);
        end
        rst = 1'b0; tick();
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k <= 4) return 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
        if (k == 5) return 32'(DEPTH * 4 - 4 + $urandom_range(0, 3));
        if (k <= 8) return BASE + 32'($urandom_range(0, 3) * 4 + $urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) return BASE + 32'h10 + 32'($urandom_range(0, 3) * 4);
        return 32'(DEPTH * 4);
    endfunction

    task automatic test_random();
        logic [31:0] mem_m [int];
        logic [7:0]  q [$];
        logic        ovf_m, halt_m, bad_m, cyc_known;
        logic [31:0] cyc_m, exp, a, d;
        logic        exp_known, c, w, rdy, r, is_pop, cyc_wr;
        int          off, sz;

        rst = 1'b1; con_ready = 1'b0; drive(1'b0, 1'b0, 32'h0, 32'h0); tick();
        rst = 1'b0;
        ovf_m = 1'b0; halt_m = 1'b0; bad_m = 1'b0; cyc_m = 32'h0; cyc_known = 1'b0;

        for (int n = 0; n < 800; n++) begin
            r   = ($urandom_range(0, 99) == 0);
            c   = ($urandom_range(0, 9) < 8);
            w   = $urandom_range(0, 1) == 1;
            rdy = ($urandom_range(0, 3) == 0);
            a   = rand_addr();
            d   = $urandom;
            rst = r; con_ready = rdy; drive(c, w, a, d);
            #1;

            sz = q.size();
            exp = 32'h0; exp_known = 1'b1; off = -1;
            if (a >= BASE && a < BASE + 32'd16) off = int'((a - BASE) >> 2);
            if (!r && c) begin
                if (a < 32'(DEPTH * 4)) begin
                    if (mem_m.exists(int'(a >> 2))) exp = mem_m[int'(a >> 2)];
                    else exp_known = 1'b0;
                end else if (off == 0) begin
                    exp = {25'b0, 3'(sz), 1'b0, ovf_m, sz == 4, sz == 0};
                end else if (off == 1) begin
`ifdef DMEM_CYCLE_CNT_EN
                    exp = cyc_m; exp_known = cyc_known;
`endif
                end else if (off == 2) begin
                    exp = {31'b0, halt_m};
                end
            end
            if (exp_known) begin
                n_checks++; if (rdata !== exp) begin n_fail++; $display("FAIL rnd_rdata@%0d: addr %h got %h want %h", n, a, rdata, exp); end
            end
            n_checks++; if (con_valid !== (sz != 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", n, con_valid, sz != 0); end
            n_checks++; if (con_data !== (sz != 0 ? q[0] : 8'h0)) begin
                n_fail++; $display("FAIL rnd_data@%0d: got %h want %h", n, con_data, sz != 0 ? q[0] : 8'h0);
            end
            n_checks++; if (halt !== halt_m) begin n_fail++; $display("FAIL rnd_halt@%0d: got %b want %b", n, halt, halt_m); end
            n_checks++; if (bad !== bad_m) begin n_fail++; $display("FAIL rnd_bad@%0d: got %b want %b", n, bad, bad_m); end

            if (r) begin
                q.delete(); ovf_m = 1'b0; halt_m = 1'b0; bad_m = 1'b0; cyc_m = 32'h0; cyc_known = 1'b0;
            end else begin
                is_pop = (sz != 0) && rdy;
                cyc_wr = 1'b0;
                if (is_pop) void'(q.pop_front());
                if (c) begin
                    if (a < 32'(DEPTH * 4)) begin
                        if (w) mem_m[int'(a >> 2)] = d;
                    end else if (off == 0) begin
                        if (w) begin
                            if (sz < 4 || is_pop) q.push_back(d[7:0]);
                            else ovf_m = 1'b1;
                        end
                    end else if (off == 1) begin
`ifdef DMEM_CYCLE_CNT_EN
                        if (w) begin cyc_m = d; cyc_known = 1'b1; cyc_wr = 1'b1; end
`endif
                    end else if (off == 2) begin
                        if (w && d[0]) halt_m = 1'b1;
                    end else if (off == 3) begin
                        if (w) ovf_m = 1'b0;
                    end else begin
                        bad_m = 1'b1;
                    end
                end
                if (!cyc_wr) cyc_m = cyc_m + 32'd1;
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; con_ready = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_ram();
        test_same_cycle();
        test_console_ovf();
        test_full_push_pop();
        test_cycle();
        test_halt_bad();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
